chip8_draw_engine: RTL and testbench
====================================

# chip8_draw_engine

Owns the 64x32 monochrome CHIP-8 framebuffer and executes the two display instructions, 00E0 (clear) and DXYN (sprite XOR-draw with collision flag). The CPU issues a command, the engine fetches sprite bytes from main memory row by row and XORs them into the framebuffer. The framebuffer is exported as the row-major `display` array consumed directly by the downstream VGA scan-out stage.

## Interface
- `ADDR_WIDTH`, 12: width of the memory address (CHIP-8 I register).
- `cpu_clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: engine idle; a command is accepted on an edge with `cmd_valid && cmd_ready`.
- `cmd_clear` in 1: 1 = clear screen (00E0), 0 = draw sprite (DXYN).
- `cmd_x` in 8: Vx value; start column is `cmd_x[5:0]`.
- `cmd_y` in 8: Vy value; start row is `cmd_y[4:0]`.
- `cmd_n` in 4: sprite height N, 0..15.
- `cmd_addr` in ADDR_WIDTH: sprite base address (I).
- `mem_rd` out 1: memory read strobe.
- `mem_addr` out ADDR_WIDTH: read address, valid while `mem_rd` is high.
- `mem_rdata` in 8: read data, valid exactly one cycle after `mem_rd`.
- `done` out 1: one-cycle completion pulse.
- `collision` out 1: VF result of the last command.
- `display` out [63:0] x [31:0]: framebuffer, row-major; pixel (x,y) is `display[y][63-x]`, so bit 63 is the leftmost pixel.

## Operation
- FSM states: IDLE, CLEAR, FETCH, WRITE, DONE. `cmd_ready` = (state == IDLE).
- Acceptance latches x0 = `cmd_x[5:0]`, y0 = `cmd_y[4:0]`, N, base, clears `collision`, and resets the row counter i to 0. Command inputs are ignored at all other times.
- Clear: CLEAR zeroes one row per cycle, rows 0..31 (5-bit counter), then DONE. `collision` stays 0.
- Draw, N = 0: goes directly to DONE with no memory access and `collision` = 0.
- Draw, N > 0: FETCH drives `mem_rd`=1 and `mem_addr` = base + i, truncated to ADDR_WIDTH so the address wraps. WRITE takes `mem_rdata` as byte b, where b[7] is the leftmost pixel. For each set bit j, the target is column x0+(7-j) and row y0+i. The engine XORs the pixel and sets `collision` if that pixel was 1 before. i increments; after row N-1 the FSM goes to DONE, otherwise back to FETCH.
- Clipping (default): columns ≥ 64 are dropped. Rows ≥ 32 write nothing, but the fetch still happens, so timing is independent of position.
- DONE asserts `done` for one cycle, then the FSM returns to IDLE.
- `collision` holds its value until the next accepted command.
- `display` changes only on `cpu_clk` edges in CLEAR or WRITE. Synchronizing it into the pixel-clock domain is the top level's responsibility.
- Reset (any time, including mid-command): state IDLE, all `display` bits 0, `collision` 0, `done` 0, `mem_rd` 0, `mem_addr` 0, i 0. Any partial draw is abandoned.

## Timing
- Command accepted at edge k:
  - Clear: CLEAR occupies cycles k+1..k+32, `done` is high in cycle k+33, and `cmd_ready` is high from cycle k+34.
  - Draw N > 0: row i FETCH is in cycle k+1+2i and its WRITE in cycle k+2+2i. `done` is high in cycle k+1+2N, and `cmd_ready` is high from cycle k+2+2N.
  - Draw N = 0: `done` is high in cycle k+1.
- A row's XOR result and the updated `collision` are visible the cycle after its WRITE.
- Outputs are registered except `cmd_ready`, which is decoded from state.

## Configuration
- `DRAW_WRAP_EN`: when defined, pixels wrap instead of clipping. The column is (x0+7-j) mod 64 and the row is (y0+i) mod 32, and every fetched row is written. When undefined, clipping applies as described above. Timing is identical in both modes.

## Test plan
- Reset, then clear: all 32 `display` rows are 0, `done` pulses exactly 33 cycles after acceptance, and `collision` = 0.
- Draw x=0, y=0, N=1, memory[0x200]=0xF0: `display[0]` = 0xF000_0000_0000_0000 and `collision` = 0. Repeating the same draw returns the row to 0 with `collision` = 1.
- Draw x=60, y=30, N=3, bytes 0xFF: rows 30 and 31 get bits [3:0] = 0xF and row 0 is untouched. With `DRAW_WRAP_EN`, rows 30, 31 and 0 each equal 0xF000_0000_0000_000F. `mem_addr` follows base, base+1, base+2 in both modes.
- Draw with base=0xFFF, N=2: the second fetch address is 0x000, and `done` arrives at cycle k+5.
- Draw N=0 with `cmd_valid` held high: `done` is at k+1, `collision` = 0, there is no `mem_rd`, and the next command is accepted at k+2.
- Assert `rst_n` low during row 2 of an N=5 draw: `display` is immediately 0, `cmd_ready` goes to 1 after release, and no further `mem_rd` is issued.

Source files
------------

// File: rtl/chip8_draw_engine.sv
// CHIP-8 display engine: owns the 64x32 framebuffer and runs 00E0 (clear) and DXYN (XOR sprite draw).
// Define DRAW_WRAP_EN to wrap sprites around the screen edges instead of clipping them.
module chip8_draw_engine #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  cpu_clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_clear,
  input  logic [7:0]            cmd_x,
  input  logic [7:0]            cmd_y,
  input  logic [3:0]            cmd_n,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic                  done,
  output logic                  collision,
  output logic [31:0][63:0]     display
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                  state_q;
  logic [5:0]              x0_q;
  logic [4:0]              y0_q;
  logic [3:0]              n_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [4:0]              i_q;
  logic                    collision_q;
  logic                    done_q;
  logic                    mem_rd_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [31:0][63:0]       display_q;

  // Only the low bits of Vx/Vy address the screen; the rest are ignored.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{cmd_x[7:6], cmd_y[7:5]};

  logic [5:0]            row_sum_d;
  logic [4:0]            row_idx_d;
  logic                  row_en_d;
  logic [63:0]           sprite_line_d;
  logic [63:0]           mask_d;
  logic [63:0]           cur_row_d;
  logic                  hit_d;
  logic                  last_row_d;
  logic [4:0]            i_d;
  logic [ADDR_WIDTH-1:0] addr_d;

  always_comb begin
    row_sum_d     = {1'b0, y0_q} + {1'b0, i_q};
    row_idx_d     = row_sum_d[4:0];
    // Bit 63 is the leftmost pixel, so shifting right by x0 moves the sprite to column x0.
    sprite_line_d = {mem_rdata, 56'h0};
`ifdef DRAW_WRAP_EN
    row_en_d      = 1'b1;
    mask_d        = (sprite_line_d >> x0_q) | (sprite_line_d << (7'd64 - {1'b0, x0_q}));
`else
    row_en_d      = ~row_sum_d[5];
    mask_d        = sprite_line_d >> x0_q;
`endif
    cur_row_d     = display_q[row_idx_d];
    hit_d         = row_en_d & (|(cur_row_d & mask_d));
    last_row_d    = (i_q[3:0] == (n_q - 4'd1));
    i_d           = i_q + 5'd1;
    addr_d        = base_q + ADDR_WIDTH'(i_d);
  end

  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      n_q         <= '0;
      base_q      <= '0;
      i_q         <= '0;
      collision_q <= 1'b0;
      done_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      display_q   <= '0;
    end else begin
      done_q   <= 1'b0;
      mem_rd_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            x0_q        <= cmd_x[5:0];
            y0_q        <= cmd_y[4:0];
            n_q         <= cmd_n;
            base_q      <= cmd_addr;
            i_q         <= '0;
            collision_q <= 1'b0;
            if (cmd_clear) begin
              state_q <= S_CLEAR;
            end else if (cmd_n == 4'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_FETCH;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= cmd_addr;
            end
          end
        end
        S_CLEAR: begin
          display_q[i_q] <= '0;
          i_q            <= i_d;
          if (i_q == 5'd31) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_FETCH: begin
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          // Clipped rows still consume their fetch so draw time never depends on position.
          if (row_en_d) begin
            display_q[row_idx_d] <= cur_row_d ^ mask_d;
          end
          if (hit_d) begin
            collision_q <= 1'b1;
          end
          i_q <= i_d;
          if (last_row_d) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q    <= S_FETCH;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= addr_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign done      = done_q;
  assign collision = collision_q;
  assign display   = display_q;

endmodule

// File: tb/tb_chip8_draw_engine.sv
// Directed self-checking bench for chip8_draw_engine with a registered sprite memory model.
// Expectations follow DRAW_WRAP_EN the same way the design does.
module tb_chip8_draw_engine;

  logic             cpu_clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_clear;
  logic [7:0]       cmd_x;
  logic [7:0]       cmd_y;
  logic [3:0]       cmd_n;
  logic [11:0]      cmd_addr;
  logic             mem_rd;
  logic [11:0]      mem_addr;
  logic [7:0]       mem_rdata;
  logic             done;
  logic             collision;
  logic [31:0][63:0] display;

  chip8_draw_engine #(.ADDR_WIDTH(12)) dut (
    .cpu_clk   (cpu_clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_clear (cmd_clear),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_n     (cmd_n),
    .cmd_addr  (cmd_addr),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .done      (done),
    .collision (collision),
    .display   (display)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  logic [7:0] mem [4096];
  int         cyc = 0;
  int         rd_cnt = 0;
  int         acc_log[$];
  int         done_log[$];
  logic [11:0] addr_log[$];

  int n_assert = 0;
  int n_fail   = 0;

  // Edge-accurate monitor: logs acceptances, done pulses and read addresses by edge number.
  always @(posedge cpu_clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) acc_log.push_back(cyc);
    if (done) done_log.push_back(cyc);
    if (mem_rd) begin
      rd_cnt <= rd_cnt + 1;
      addr_log.push_back(mem_addr);
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int r = 0; r < 32; r++) check($sformatf("%s_row%0d", tag, r), display[r], 64'h0);
  endtask

  task automatic run_cmd(input logic clr, input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] n, input logic [11:0] a, output int lat);
    int nd;
    @(negedge cpu_clk);
    check("ready_before_cmd", 64'(cmd_ready), 64'h1);
    cmd_clear = clr;
    cmd_x     = x;
    cmd_y     = y;
    cmd_n     = n;
    cmd_addr  = a;
    cmd_valid = 1'b1;
    nd        = done_log.size();
    @(negedge cpu_clk);
    cmd_valid = 1'b0;
    for (int t = 0; t < 100 && done_log.size() == nd; t++) @(negedge cpu_clk);
    check("done_seen", 64'(done_log.size() > nd), 64'h1);
    if (done_log.size() > nd && acc_log.size() > 0) lat = done_log[$] - acc_log[$];
    else lat = -1;
    $display("cmd clear=%0d x=%0d y=%0d n=%0d addr=%h latency=%0d collision=%0d",
             clr, x, y, n, a, lat, collision);
  endtask

  int lat;
  int rd0;
  int nd0;
  int na0;
  int ab;

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_clear = 1'b0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_n     = '0;
    cmd_addr  = '0;
    for (int k = 0; k < 4096; k++) mem[k] = 8'h00;
    mem[12'h200] = 8'hF0;
    mem[12'h300] = 8'hFF;
    mem[12'h301] = 8'hFF;
    mem[12'h302] = 8'hFF;
    mem[12'hFFF] = 8'h81;
    mem[12'h000] = 8'h3C;
    for (int k = 0; k < 5; k++) mem[12'h400 + k] = 8'hFF;

    // Reset state
    repeat (3) @(negedge cpu_clk);
    check("rst_ready", 64'(cmd_ready), 64'h1);
    check("rst_done", 64'(done), 64'h0);
    check("rst_mem_rd", 64'(mem_rd), 64'h0);
    check("rst_mem_addr", 64'(mem_addr), 64'h0);
    check("rst_collision", 64'(collision), 64'h0);
    check_all_zero("rst_display");
    rst_n = 1'b1;

    // Clear after reset
    run_cmd(1'b1, 8'd0, 8'd0, 4'd0, 12'h000, lat);
    check("clear_latency", 64'(lat), 64'd33);
    check("clear_collision", 64'(collision), 64'h0);
    check_all_zero("clear1");

    // Simple draw and its undo with collision
    run_cmd(1'b0, 8'd0, 8'd0, 4'd1, 12'h200, lat);
    check("draw1_latency", 64'(lat), 64'd3);
    check("draw1_row0", display[0], 64'hF000_0000_0000_0000);
    check("draw1_collision", 64'(collision), 64'h0);
    run_cmd(1'b0, 8'd0, 8'd0, 4'd1, 12'h200, lat);
    check("draw2_row0", display[0], 64'h0);
    check("draw2_collision", 64'(collision), 64'h1);

    // Corner draw: clipping vs wrapping
    ab = addr_log.size();
    run_cmd(1'b0, 8'd60, 8'd30, 4'd3, 12'h300, lat);
    check("corner_latency", 64'(lat), 64'd7);
    check("corner_rd_count", 64'(addr_log.size() - ab), 64'd3);
    if (addr_log.size() - ab == 3) begin
      check("corner_addr0", 64'(addr_log[ab]), 64'h300);
      check("corner_addr1", 64'(addr_log[ab+1]), 64'h301);
      check("corner_addr2", 64'(addr_log[ab+2]), 64'h302);
    end
`ifdef DRAW_WRAP_EN
    check("corner_row30", display[30], 64'hF000_0000_0000_000F);
    check("corner_row31", display[31], 64'hF000_0000_0000_000F);
    check("corner_row0", display[0], 64'hF000_0000_0000_000F);
`else
    check("corner_row30", display[30], 64'h0000_0000_0000_000F);
    check("corner_row31", display[31], 64'h0000_0000_0000_000F);
    check("corner_row0", display[0], 64'h0);
`endif
    check("corner_collision", 64'(collision), 64'h0);

    // Address wrap at the top of memory
    ab = addr_log.size();
    run_cmd(1'b0, 8'd8, 8'd5, 4'd2, 12'hFFF, lat);
    check("wrapaddr_latency", 64'(lat), 64'd5);
    check("wrapaddr_rd_count", 64'(addr_log.size() - ab), 64'd2);
    if (addr_log.size() - ab == 2) begin
      check("wrapaddr_addr0", 64'(addr_log[ab]), 64'hFFF);
      check("wrapaddr_addr1", 64'(addr_log[ab+1]), 64'h000);
    end
    check("wrapaddr_row5", display[5], 64'h0081_0000_0000_0000);
    check("wrapaddr_row6", display[6], 64'h003C_0000_0000_0000);
    check("wrapaddr_collision", 64'(collision), 64'h0);

    // Partial overlap sets collision; upper bits of Vx/Vy are ignored
    run_cmd(1'b0, 8'hCC, 8'hE5, 4'd1, 12'h000, lat);
    check("overlap_row5", display[5], 64'h0082_C000_0000_0000);
    check("overlap_collision", 64'(collision), 64'h1);

    // N=0 with cmd_valid held high
    @(negedge cpu_clk);
    rd0 = rd_cnt;
    na0 = acc_log.size();
    nd0 = done_log.size();
    cmd_clear = 1'b0;
    cmd_n     = 4'd0;
    cmd_addr  = 12'h123;
    cmd_valid = 1'b1;
    for (int t = 0; t < 20 && acc_log.size() < na0 + 2; t++) @(negedge cpu_clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge cpu_clk);
    check("n0_accepts", 64'(acc_log.size() - na0), 64'd2);
    check("n0_dones", 64'(done_log.size() - nd0), 64'd2);
    if (acc_log.size() >= na0 + 2 && done_log.size() >= nd0 + 1) begin
      check("n0_done_latency", 64'(done_log[nd0] - acc_log[na0]), 64'd1);
      check("n0_next_accept", 64'(acc_log[na0+1] - acc_log[na0]), 64'd2);
    end
    check("n0_no_mem_rd", 64'(rd_cnt - rd0), 64'd0);
    check("n0_collision", 64'(collision), 64'h0);
    $display("cmd n=0 held-valid accepts=%0d dones=%0d", acc_log.size() - na0, done_log.size() - nd0);

    // Reset during row 2 of an N=5 draw
    @(negedge cpu_clk);
    rd0 = rd_cnt;
    nd0 = done_log.size();
    cmd_clear = 1'b0;
    cmd_x     = 8'd0;
    cmd_y     = 8'd10;
    cmd_n     = 4'd5;
    cmd_addr  = 12'h400;
    cmd_valid = 1'b1;
    @(negedge cpu_clk);
    cmd_valid = 1'b0;
    for (int t = 0; t < 20 && rd_cnt < rd0 + 3; t++) @(negedge cpu_clk);
    check("midrst_fetch_row2", 64'(rd_cnt - rd0), 64'd3);
    check("midrst_row10_before", display[10], 64'hFF00_0000_0000_0000);
    check("midrst_row11_before", display[11], 64'hFF00_0000_0000_0000);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst_display");
    check("midrst_mem_rd", 64'(mem_rd), 64'h0);
    @(negedge cpu_clk);
    rd0 = rd_cnt;
    rst_n = 1'b1;
    repeat (12) @(negedge cpu_clk);
    check("midrst_ready", 64'(cmd_ready), 64'h1);
    check("midrst_no_more_rd", 64'(rd_cnt - rd0), 64'd0);
    check("midrst_no_done", 64'(done_log.size() - nd0), 64'd0);
    $display("cmd reset during N=5 draw, reads after reset=%0d", rd_cnt - rd0);

    // Clear wipes drawn content
    run_cmd(1'b0, 8'd0, 8'd0, 4'd1, 12'h200, lat);
    check("predraw_row0", display[0], 64'hF000_0000_0000_0000);
    run_cmd(1'b1, 8'd3, 8'd3, 4'd7, 12'h200, lat);
    check("clear2_latency", 64'(lat), 64'd33);
    check("clear2_collision", 64'(collision), 64'h0);
    check_all_zero("clear2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
